piano_pwm_out: RTL and testbench



---
 rtl/piano_pkg.sv | 29 ++
 rtl/piano_sample_fifo.sv | 61 ++++++
 rtl/piano_pwm_out.sv | 133 +++++++++++++
 tb/tb_piano_pwm_out.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared definitions for the piano PWM audio output block.
// Holds the default sample width, the DC midpoint used for silence,
// the player state type and a constant-friendly ceiling log2 helper.
package piano_pkg;

  localparam int SAMPLE_W_DEFAULT = 8;

  // Mid-scale code: 50% duty cycle, i.e. the filtered output sits at DC midpoint
  localparam int unsigned MIDSCALE = 32'd1 << (SAMPLE_W_DEFAULT - 1);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  // Ceiling log2, usable in parameter and port-width expressions
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piano_sample_fifo.sv
// Small first-word-fall-through sample buffer for the PWM player.
// The head entry is always visible on 'head' while level is non-zero;
// a pop simply advances past it. Push on a full buffer and pop on an
// empty buffer are ignored. Push and pop together keep the level.
module piano_sample_fifo
  import piano_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && (level != LW'(DEPTH));
  assign pop_ok  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  // Storage array has no reset; only the pointers and level define validity
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/piano_pwm_out.sv
// PWM audio output stage for the piano synth.
// Buffers incoming samples in a small FIFO and plays each one for exactly
// one PWM period of 2^SAMPLE_W counter ticks on a single registered pin.
// sample_tick marks each load from the FIFO, underrun marks a period end
// that found the FIFO empty.
// Build option: define PIANO_PWM_HOLD_ON_UNDERRUN_EN to keep playing the
// last sample on underrun; otherwise the player falls back to mid-scale.
module piano_pwm_out
  import piano_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SAMPLE_W-1:0]         wave,
  input  logic                        wave_valid,
  output logic                        wave_ready,
  output logic                        pwm_out,
  output logic                        sample_tick,
  output logic                        underrun,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int LW = clog2(FIFO_DEPTH) + 1;
  localparam int PW = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
  localparam int unsigned MID_INT = (SAMPLE_W == SAMPLE_W_DEFAULT) ? MIDSCALE
                                                                   : (32'd1 << (SAMPLE_W - 1));
  localparam logic [SAMPLE_W-1:0] MID     = SAMPLE_W'(MID_INT);
  localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;
  localparam logic [PW-1:0]       PRE_MAX = PW'(CLK_DIV - 1);

  state_t              state;
  state_t              state_next;
  logic [SAMPLE_W-1:0] cnt;
  logic [SAMPLE_W-1:0] cnt_next;
  logic [SAMPLE_W-1:0] cur;
  logic [SAMPLE_W-1:0] cur_next;
  logic [PW-1:0]       prescaler;
  logic [PW-1:0]       prescaler_next;
  logic [SAMPLE_W-1:0] head;
  logic                push;
  logic                pop;
  logic                starved;
  logic                fifo_empty;
  logic                tick;

  assign wave_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push       = wave_valid && wave_ready && !rst;
  assign fifo_empty = (fifo_level == '0);
  assign tick       = (state == PLAY) && (prescaler == PRE_MAX);

  // Pulses are combinational so they line up with the pop; reset silences them
  assign sample_tick = pop && !rst;
  assign underrun    = starved && !rst;

  piano_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wave),
    .head  (head),
    .level (fifo_level)
  );

  // Next-state decode: start playing from IDLE, advance the period counter, reload at period end
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    cur_next       = cur;
    prescaler_next = prescaler;
    pop            = 1'b0;
    starved        = 1'b0;
    case (state)
      IDLE: begin
        cnt_next       = '0;
        prescaler_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          cur_next   = head;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          prescaler_next = '0;
          cnt_next       = cnt + SAMPLE_W'(1);
          if (cnt == CNT_MAX) begin
            if (!fifo_empty) begin
              pop      = 1'b1;
              cur_next = head;
            end else begin
              starved = 1'b1;
`ifdef PIANO_PWM_HOLD_ON_UNDERRUN_EN
              cur_next = cur;
`else
              cur_next = MID;
`endif
            end
          end
        end else begin
          prescaler_next = prescaler + PW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Player state and registered PWM pin; the pin reflects the counter/sample pair of its own cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur       <= MID;
      prescaler <= '0;
      pwm_out   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cur       <= cur_next;
      prescaler <= prescaler_next;
      pwm_out   <= (state_next == PLAY) && (cnt_next < cur_next);
    end
  end

endmodule

// File: tb/tb_piano_pwm_out.sv
// Self-checking bench for piano_pwm_out.
// Two instances run side by side: CLK_DIV=1 and CLK_DIV=3, both 8-bit with a
// 4-entry FIFO. A time-based model (sample queue plus clock phase within the
// current period) predicts every output on every cycle, and a set of
// hand-computed expectations pins the model's behaviour for key scenarios.
module tb_piano_pwm_out;

  localparam int DEPTH  = 4;
  localparam int PERIOD = 256;
  localparam int MID    = 128;
  localparam int RECMAX = 64;
`ifdef PIANO_PWM_HOLD_ON_UNDERRUN_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v [2];
  logic [7:0] w [2];
  logic       ready0, pwm0, tick0, und0;
  logic       ready1, pwm1, tick1, und1;
  logic [2:0] lvl0, lvl1;

  logic       p_rst;
  logic       p_v [2];
  logic [7:0] p_w [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit m_known = 1'b0;
  bit m_play [2];
  int m_phase [2];
  int m_cur [2];
  int m_ring [2][8];
  int m_head [2];
  int m_cnt [2];

  int hi_acc [2];
  int per_hi [2][RECMAX];
  int n_per [2];
  int tick_at [2][RECMAX];
  int n_tick [2];
  int und_at [2][RECMAX];
  int n_und [2];
  int acc_at [2][RECMAX];
  int n_acc [2];

  logic       snap_rdy [2];
  logic       snap_pwm [2];
  logic       snap_tick [2];
  logic       snap_und [2];
  logic [2:0] snap_lvl [2];

  piano_pwm_out #(.SAMPLE_W(8), .FIFO_DEPTH(DEPTH), .CLK_DIV(1)) dut_fast (
    .clk         (clk),
    .rst         (rst),
    .wave        (w[0]),
    .wave_valid  (v[0]),
    .wave_ready  (ready0),
    .pwm_out     (pwm0),
    .sample_tick (tick0),
    .underrun    (und0),
    .fifo_level  (lvl0)
  );

  piano_pwm_out #(.SAMPLE_W(8), .FIFO_DEPTH(DEPTH), .CLK_DIV(3)) dut_slow (
    .clk         (clk),
    .rst         (rst),
    .wave        (w[1]),
    .wave_valid  (v[1]),
    .wave_ready  (ready1),
    .pwm_out     (pwm1),
    .sample_tick (tick1),
    .underrun    (und1),
    .fifo_level  (lvl1)
  );

  always #5 clk = ~clk;

  function automatic int div_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int per_of(input int g, input int k);
    return (n_per[g] > k) ? per_hi[g][k] : -100000;
  endfunction

  function automatic int tick_of(input int g, input int k);
    return (n_tick[g] > k) ? tick_at[g][k] : -100000;
  endfunction

  function automatic int und_of(input int g, input int k);
    return (n_und[g] > k) ? und_at[g][k] : -100000;
  endfunction

  function automatic int acc_of(input int g, input int k);
    return (n_acc[g] > k) ? acc_at[g][k] : -100000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, need %0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_records();
    for (int g = 0; g < 2; g++) begin
      n_per[g]  = 0;
      n_tick[g] = 0;
      n_und[g]  = 0;
      n_acc[g]  = 0;
    end
  endtask

  // Compare every output of both instances with the model for the current cycle
  task automatic check_output();
    logic       d_rdy, d_pwm, d_tick, d_und;
    logic [2:0] d_lvl;
    int         dv;
    bit         e_end;
    for (int g = 0; g < 2; g++) begin
      if (g == 0) begin
        d_rdy = ready0; d_pwm = pwm0; d_tick = tick0; d_und = und0; d_lvl = lvl0;
      end else begin
        d_rdy = ready1; d_pwm = pwm1; d_tick = tick1; d_und = und1; d_lvl = lvl1;
      end
      snap_rdy[g]  = d_rdy;
      snap_pwm[g]  = d_pwm;
      snap_tick[g] = d_tick;
      snap_und[g]  = d_und;
      snap_lvl[g]  = d_lvl;
      if (d_tick === 1'b1) begin
        if (n_tick[g] < RECMAX) tick_at[g][n_tick[g]] = cyc;
        n_tick[g]++;
      end
      if (d_und === 1'b1) begin
        if (n_und[g] < RECMAX) und_at[g][n_und[g]] = cyc;
        n_und[g]++;
      end
      if (v[g] && d_rdy === 1'b1 && !rst) begin
        if (n_acc[g] < RECMAX) acc_at[g][n_acc[g]] = cyc;
        n_acc[g]++;
      end
      if (m_known) begin
        dv    = div_of(g);
        e_end = m_play[g] && (m_phase[g] == PERIOD * dv - 1);
        check($sformatf("ready%0d", g), d_rdy, m_cnt[g] != DEPTH);
        check($sformatf("level%0d", g), d_lvl, m_cnt[g]);
        check($sformatf("pwm%0d", g), d_pwm, m_play[g] && ((m_phase[g] / dv) < m_cur[g]));
        check($sformatf("sample_tick%0d", g), d_tick,
              !rst && (m_cnt[g] > 0) && (!m_play[g] || e_end));
        check($sformatf("underrun%0d", g), d_und, !rst && e_end && (m_cnt[g] == 0));
        if (m_play[g]) begin
          hi_acc[g] += (d_pwm === 1'b1) ? 1 : 0;
          if (e_end) begin
            if (n_per[g] < RECMAX) per_hi[g][n_per[g]] = hi_acc[g];
            n_per[g]++;
            hi_acc[g] = 0;
          end
        end
      end
    end
  endtask

  task automatic model_pop(input int g);
    m_cur[g]  = m_ring[g][m_head[g]];
    m_head[g] = (m_head[g] + 1) % 8;
    m_cnt[g]--;
  endtask

  // Advance the model by one clock using the inputs sampled at this edge
  task automatic model_step();
    bit do_push;
    if (rst) begin
      m_known = 1'b1;
      for (int g = 0; g < 2; g++) begin
        m_play[g]  = 1'b0;
        m_phase[g] = 0;
        m_cur[g]   = MID;
        m_head[g]  = 0;
        m_cnt[g]   = 0;
        hi_acc[g]  = 0;
      end
      return;
    end
    if (!m_known) return;
    for (int g = 0; g < 2; g++) begin
      do_push = v[g] && (m_cnt[g] != DEPTH);
      if (!m_play[g]) begin
        if (m_cnt[g] > 0) begin
          model_pop(g);
          m_play[g]  = 1'b1;
          m_phase[g] = 0;
        end
      end else if (m_phase[g] == PERIOD * div_of(g) - 1) begin
        m_phase[g] = 0;
        if (m_cnt[g] > 0) model_pop(g);
        else if (!HOLD) m_cur[g] = MID;
      end else begin
        m_phase[g]++;
      end
      if (do_push) begin
        m_ring[g][(m_head[g] + m_cnt[g]) % 8] = w[g];
        m_cnt[g]++;
      end
    end
  endtask

  // One clock: drive pending inputs at the falling edge, check, then step the model
  task automatic cycle();
    @(negedge clk);
    rst  = p_rst;
    v[0] = p_v[0];
    v[1] = p_v[1];
    w[0] = p_w[0];
    w[1] = p_w[1];
    #1;
    check_output();
    @(posedge clk);
    model_step();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_stimulus_reset();
    p_v[0] = 1'b0;
    p_v[1] = 1'b0;
    p_rst  = 1'b1;
    cycle();
    cycle();
    p_rst  = 1'b0;
  endtask

  task automatic push_wait(input int g, input logic [7:0] val);
    int start;
    start  = n_acc[g];
    p_v[g] = 1'b1;
    p_w[g] = val;
    for (int i = 0; i < 2000 && n_acc[g] == start; i++) cycle();
    p_v[g] = 1'b0;
    check($sformatf("push_done%0d", g), n_acc[g], start + 1);
  endtask

  initial begin
    int   s [6];
    bit   seen_full;
    v[0] = 1'b0; v[1] = 1'b0; w[0] = '0; w[1] = '0;
    p_rst = 1'b1; p_v[0] = 1'b0; p_v[1] = 1'b0; p_w[0] = '0; p_w[1] = '0;
    clear_records();

    // Power-on reset and the first idle cycle
    apply_stimulus_reset();
    cycle();
    check("por_level", snap_lvl[0], 0);
    check("por_ready", snap_rdy[0], 1);
    check("por_pwm", snap_pwm[0], 0);

    // Single sample: 0x40 on the fast player, two 0x10 samples on the divided player
    clear_records();
    p_v[0] = 1'b1; p_w[0] = 8'h40;
    p_v[1] = 1'b1; p_w[1] = 8'h10;
    cycle();
    p_v[0] = 1'b0;
    cycle();
    p_v[1] = 1'b0;
    check("a_acc_fast", n_acc[0], 1);
    check("a_acc_slow", n_acc[1], 2);
    run(1560);
    check("a_tick_latency", tick_of(0, 0) - acc_of(0, 0), 1);
    check("a_high_0x40", per_of(0, 0), 64);
    check("a_underrun_pos", und_of(0, 0) - tick_of(0, 0), 256);
    check("a_high_div3", per_of(1, 0), 48);
    check("a_tick_gap_div3", tick_of(1, 1) - tick_of(1, 0), 768);
    check("a_underrun_div3", und_of(1, 0) - tick_of(1, 1), 768);

    // Reset in the middle of play with samples still buffered
    push_wait(0, 8'h33);
    push_wait(0, 8'h77);
    push_wait(0, 8'h99);
    run(100);
    apply_stimulus_reset();
    clear_records();
    cycle();
    check("b_level", snap_lvl[0], 0);
    check("b_ready", snap_rdy[0], 1);
    check("b_pwm", snap_pwm[0], 0);
    check("b_tick", snap_tick[0], 0);
    check("b_underrun", snap_und[0], 0);
    check("b_level_slow", snap_lvl[1], 0);
    run(5);
    check("b_idle_ticks", n_tick[0], 0);
    check("b_idle_underruns", n_und[0], 0);

    // Backpressure: six samples offered back to back
    for (int k = 0; k < 6; k++) s[k] = $urandom_range(0, 255);
    seen_full = 1'b0;
    for (int i = 0; i < 3000 && n_acc[0] < 6; i++) begin
      p_v[0] = 1'b1;
      p_w[0] = s[n_acc[0]];
      cycle();
      if (snap_lvl[0] == 3'd4) begin
        seen_full = 1'b1;
        check("c_full_not_ready", snap_rdy[0], 0);
      end
    end
    p_v[0] = 1'b0;
    check("c_seen_full", seen_full, 1);
    check("c_burst_accepts", acc_of(0, 4) - acc_of(0, 0), 4);
    check("c_held_accept", acc_of(0, 5) - tick_of(0, 1), 1);
    run(6 * PERIOD + 10);
    for (int k = 0; k < 6; k++) check($sformatf("c_order%0d", k), per_of(0, k), s[k]);

    // Extremes back to back
    apply_stimulus_reset();
    clear_records();
    push_wait(0, 8'h00);
    push_wait(0, 8'hFF);
    run(2 * PERIOD + 10);
    check("d_high_0x00", per_of(0, 0), 0);
    check("d_high_0xff", per_of(0, 1), 255);

    // Underrun fill value after a lone 0xC0
    apply_stimulus_reset();
    clear_records();
    push_wait(0, 8'hC0);
    run(3 * PERIOD + 10);
    check("e_high_first", per_of(0, 0), 192);
    check("e_high_underrun", per_of(0, 1), HOLD ? 192 : 128);
    check("e_underrun_count", n_und[0], 3);
    check("e_underrun_gap", und_of(0, 1) - und_of(0, 0), 256);

    // Randomised traffic alternating sparse and dense phases, with rare resets
    apply_stimulus_reset();
    for (int i = 0; i < 4000; i++) begin
      p_rst = ($urandom_range(0, 999) == 0);
      for (int g = 0; g < 2; g++) begin
        p_v[g] = ($urandom_range(0, 99) < (((i / 1000) % 2 == 1) ? 90 : 1));
        p_w[g] = 8'($urandom_range(0, 255));
      end
      cycle();
    end
    p_rst = 1'b0;
    p_v[0] = 1'b0;
    p_v[1] = 1'b0;
    run(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
